// File: rtl/ascii_dec_parser.sv
// Parses CR/LF-terminated ASCII decimal lines from a UART RX byte stream into an
// 8-bit value; malformed, oversize or stalled lines raise a single error strobe.
module ascii_dec_parser #(
    parameter int MAX_DIGITS     = 3,
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] value,
    output logic       value_valid,
    output logic       err,
    output logic       busy
);

    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CNT_W = $clog2(MAX_DIGITS + 1);

    typedef enum logic [1:0] {IDLE, ACCUM, DISCARD} state_t;

    state_t           state, state_nxt;
    logic [7:0]       acc, acc_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [TMR_W-1:0] tmr, tmr_nxt;
    logic [7:0]       value_nxt;
    logic             vld_nxt, err_nxt;

    logic             is_digit, is_term, digits_full, overflow, expire;
    logic [3:0]       digit;
    logic [11:0]      mac;

    // 255*10 + 9 fits in 12 bits, so the overflow test sees the untruncated sum.
    function automatic logic [11:0] mac10(input logic [7:0] a, input logic [3:0] d);
        return ({4'b0, a} * 12'd10) + {8'b0, d};
    endfunction

    assign is_digit    = (rx_data >= 8'h30) && (rx_data <= 8'h39);
    assign is_term     = (rx_data == 8'h0D) || (rx_data == 8'h0A);
    assign digit       = rx_data[3:0];
    assign mac         = mac10(acc, digit);
    assign overflow    = (mac > 12'd255);
    assign digits_full = (cnt == CNT_W'(MAX_DIGITS));
    // A byte arriving on the expiry cycle takes priority over the timeout.
    assign expire      = (state != IDLE) && !rx_valid && (tmr == TMR_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            acc         <= '0;
            cnt         <= '0;
            tmr         <= '0;
            value       <= '0;
            value_valid <= 1'b0;
            err         <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_nxt;
            acc         <= acc_nxt;
            cnt         <= cnt_nxt;
            tmr         <= tmr_nxt;
            value       <= value_nxt;
            value_valid <= vld_nxt;
            err         <= err_nxt;
            busy        <= (state_nxt != IDLE);
        end
    end

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        unique case (state)
            IDLE: begin
                if (rx_valid && is_digit) begin
                    state_nxt = ACCUM;
                    acc_nxt   = {4'b0, digit};
                    cnt_nxt   = CNT_W'(1);
                end else if (rx_valid && !is_term) begin
                    state_nxt = DISCARD;
                end
            end
            ACCUM: begin
                if (rx_valid) begin
                    if (is_digit && !digits_full && !overflow) begin
                        acc_nxt = mac[7:0];
                        cnt_nxt = cnt + CNT_W'(1);
                    end else if (is_term) begin
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = DISCARD;
                    end
                end else if (expire) begin
                    state_nxt = IDLE;
                end
            end
            DISCARD: begin
                if ((rx_valid && is_term) || expire) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        tmr_nxt = (state_nxt == IDLE || rx_valid) ? '0 : tmr + TMR_W'(1);
    end

    always_comb begin
        value_nxt = value;
        vld_nxt   = 1'b0;
        err_nxt   = 1'b0;
        unique case (state)
            IDLE: err_nxt = rx_valid && !is_digit && !is_term;
            ACCUM: begin
                if (rx_valid) begin
                    if (is_digit) begin
                        err_nxt = digits_full || overflow;
                    end else if (is_term) begin
                        vld_nxt   = 1'b1;
                        value_nxt = acc;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end else begin
                    err_nxt = expire;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ascii_dec_parser.sv
// Randomised and directed bench for ascii_dec_parser against a line-level model
// that works on the digit string of the current line rather than DUT state.
module tb_ascii_dec_parser;

    localparam int MAXD = 3;
    localparam int TO   = 16;

    typedef int q_t[$];

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic [7:0] value;
    logic       value_valid, err, busy;

    int n_vec = 0;
    int n_bad = 0;

    // line-level reference state
    int         m_digits[$];
    bit         m_inline, m_disc;
    int         m_idle;
    logic [7:0] m_value;
    logic       m_vv, m_err, m_busy;

    ascii_dec_parser #(.MAX_DIGITS(MAXD), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .value(value), .value_valid(value_valid), .err(err), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        m_digits.delete();
        m_inline = 0; m_disc = 0; m_idle = 0;
        m_value = 8'h00; m_vv = 0; m_err = 0; m_busy = 0;
    endfunction

    function automatic int line_num();
        int n;
        n = 0;
        foreach (m_digits[i]) n = n * 10 + m_digits[i];
        return n;
    endfunction

    function automatic void model_step(input bit v, input logic [7:0] b);
        bit is_dig, is_term;
        is_dig  = (b >= 8'h30) && (b <= 8'h39);
        is_term = (b == 8'h0D) || (b == 8'h0A);
        m_vv = 0; m_err = 0;
        if (v) begin
            m_idle = 0;
            if (m_disc) begin
                if (is_term) m_disc = 0;
            end else if (is_dig) begin
                m_digits.push_back(int'(b) - 48);
                m_inline = 1;
                if (m_digits.size() > MAXD || line_num() > 255) begin
                    m_err = 1; m_disc = 1; m_inline = 0; m_digits.delete();
                end
            end else if (is_term) begin
                if (m_inline) begin
                    m_value = 8'(line_num());
                    m_vv = 1;
                end
                m_inline = 0; m_digits.delete();
            end else begin
                m_err = 1; m_disc = 1; m_inline = 0; m_digits.delete();
            end
        end else if (m_inline || m_disc) begin
            if (m_idle == TO - 1) begin
                m_err = m_inline;
                m_inline = 0; m_disc = 0; m_idle = 0; m_digits.delete();
            end else begin
                m_idle++;
            end
        end
        m_busy = m_inline || m_disc;
    endfunction

    // 'C' = CR, 'L' = LF, '.' = idle cycle; other characters are sent as-is.
    function automatic q_t str2q(input string s);
        q_t q;
        for (int i = 0; i < s.len(); i++) begin
            if (s[i] == "C")      q.push_back(13);
            else if (s[i] == "L") q.push_back(10);
            else if (s[i] == ".") q.push_back(-1);
            else                  q.push_back(int'(s[i]));
        end
        return q;
    endfunction

    task automatic drive(input int b);
        if (b < 0) begin
            rx_valid = 1'b0;
            rx_data  = 8'($urandom);
        end else begin
            rx_valid = 1'b1;
            rx_data  = 8'(b);
        end
        @(posedge clk);
        model_step(rx_valid, rx_data);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rx_valid = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        if ({value, value_valid, err, busy} !== 11'h0) begin
            n_bad++;
            $display("FAIL reset_state: got %h/%b/%b/%b want 00/0/0/0", value, value_valid, err, busy);
        end
        n_vec++;
        rst = 1'b0;
    endtask

    task automatic test_lines();
        q_t q;
        q = str2q("128C256C255L0073CCL9a5C..");
        foreach (q[i]) begin
            drive(q[i]);
            if ({value, value_valid, err, busy} !== {m_value, m_vv, m_err, m_busy}) begin
                n_bad++;
                $display("FAIL lines[%0d]: got %h/%b/%b/%b want %h/%b/%b/%b", i,
                         value, value_valid, err, busy, m_value, m_vv, m_err, m_busy);
            end
            n_vec++;
            if (i == 3 && value !== 8'h80) begin
                n_bad++;
                $display("FAIL value_128: got %h want 80", value);
            end
            if (i == 11 && value !== 8'hFF) begin
                n_bad++;
                $display("FAIL value_255: got %h want ff", value);
            end
        end
    endtask

    task automatic test_timeout();
        q_t q;
        int errs;
        q = str2q("4................");
        foreach (q[i]) begin
            drive(q[i]);
            if ({value, value_valid, err, busy} !== {m_value, m_vv, m_err, m_busy}) begin
                n_bad++;
                $display("FAIL timeout[%0d]: got %h/%b/%b/%b want %h/%b/%b/%b", i,
                         value, value_valid, err, busy, m_value, m_vv, m_err, m_busy);
            end
            n_vec++;
        end
        if (err !== 1'b1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout_expiry: got err=%b busy=%b want err=1 busy=0", err, busy);
        end
        n_vec++;
        errs = 0;
        q = str2q(".4...............2C.");
        foreach (q[i]) begin
            drive(q[i]);
            errs += int'(err);
            if ({value, value_valid, err, busy} !== {m_value, m_vv, m_err, m_busy}) begin
                n_bad++;
                $display("FAIL byte_wins[%0d]: got %h/%b/%b/%b want %h/%b/%b/%b", i,
                         value, value_valid, err, busy, m_value, m_vv, m_err, m_busy);
            end
            n_vec++;
        end
        if (value !== 8'd42 || errs != 0) begin
            n_bad++;
            $display("FAIL byte_wins_value: got value=%0d errs=%0d want value=42 errs=0", value, errs);
        end
        n_vec++;
    endtask

    task automatic test_reset_midline();
        q_t q;
        drive(int'("1"));
        drive(int'("9"));
        rst = 1'b1;
        rx_valid = 1'b0;
        model_reset();
        #1;
        if ({value, value_valid, err, busy} !== 11'h0) begin
            n_bad++;
            $display("FAIL async_reset: got %h/%b/%b/%b want 00/0/0/0", value, value_valid, err, busy);
        end
        n_vec++;
        repeat (2) begin
            @(posedge clk);
            #1;
            if ({value, value_valid, err, busy} !== 11'h0) begin
                n_bad++;
                $display("FAIL reset_hold: got %h/%b/%b/%b want 00/0/0/0", value, value_valid, err, busy);
            end
            n_vec++;
        end
        rst = 1'b0;
        q = str2q("3C.");
        foreach (q[i]) begin
            drive(q[i]);
            if ({value, value_valid, err, busy} !== {m_value, m_vv, m_err, m_busy}) begin
                n_bad++;
                $display("FAIL after_reset[%0d]: got %h/%b/%b/%b want %h/%b/%b/%b", i,
                         value, value_valid, err, busy, m_value, m_vv, m_err, m_busy);
            end
            n_vec++;
        end
        if (value !== 8'd3) begin
            n_bad++;
            $display("FAIL reset_value: got %0d want 3", value);
        end
        n_vec++;
    endtask

    task automatic test_back_to_back();
        q_t q;
        q = str2q("12C34L5C7LC");
        foreach (q[i]) begin
            drive(q[i]);
            if ({value, value_valid, err, busy} !== {m_value, m_vv, m_err, m_busy}) begin
                n_bad++;
                $display("FAIL b2b[%0d]: got %h/%b/%b/%b want %h/%b/%b/%b", i,
                         value, value_valid, err, busy, m_value, m_vv, m_err, m_busy);
            end
            n_vec++;
        end
    endtask

    task automatic test_random();
        q_t q;
        int r;
        for (int t = 0; t < 600; t++) begin
            r = int'($urandom_range(0, 99));
            q.delete();
            if (r < 55)      q.push_back(48 + int'($urandom_range(0, 9)));
            else if (r < 68) q.push_back($urandom_range(0, 1) ? 13 : 10);
            else if (r < 76) q.push_back(int'($urandom_range(0, 255)));
            else if (r < 94) q.push_back(-1);
            else repeat ($urandom_range(12, 20)) q.push_back(-1);
            foreach (q[i]) begin
                drive(q[i]);
                if ({value, value_valid, err, busy} !== {m_value, m_vv, m_err, m_busy}) begin
                    n_bad++;
                    $display("FAIL random[%0d]: got %h/%b/%b/%b want %h/%b/%b/%b", t,
                             value, value_valid, err, busy, m_value, m_vv, m_err, m_busy);
                end
                n_vec++;
                if (value_valid === 1'b1 && err === 1'b1) begin
                    n_bad++;
                    $display("FAIL strobe_overlap: got vv=1 err=1 want not both");
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_lines();
        test_timeout();
        test_reset_midline();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/ascii_dec_parser.md
# ascii_dec_parser

Receive-side companion to the binary-to-ASCII-decimal conversion on the transmit path. Consumes bytes from the UART receiver, parses a line of ASCII decimal digits terminated by CR or LF, and presents the result as an 8-bit binary value with a one-cycle valid strobe. Malformed, oversize or stalled lines produce a one-cycle error strobe and are discarded. Sits between the UART RX byte interface and the register or threshold logic that consumes host-written values.

## Interface
- MAX_DIGITS, 3, maximum digits accepted per line (1..3); leading zeros count.
- TIMEOUT_CYCLES, 50_000_000, idle cycles allowed between bytes of a partial line before abort; counter width is $clog2(TIMEOUT_CYCLES+1).

- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- rx_data  input  8  received byte; sampled only when rx_valid=1.
- rx_valid  input  1  one-cycle strobe per received byte; back-to-back cycles legal.
- value  output  8  last successfully parsed value; held until the next success.
- value_valid  output  1  one-cycle pulse when value updates.
- err  output  1  one-cycle pulse per rejected line.
- busy  output  1  high while a line is partially received (state ≠ IDLE).

## Operation
- Byte classes: DIGIT = 0x30..0x39; TERM = 0x0D or 0x0A; OTHER = everything else.
- States: IDLE, ACCUM, DISCARD. Registers: acc (8 bits), cnt (digit count, 0..MAX_DIGITS), tmr (timeout counter).
- IDLE:
  - DIGIT: acc = d, cnt = 1, go ACCUM.
  - TERM: ignored (empty line, so CR LF pairs are harmless); no strobe.
  - OTHER: err pulse, go DISCARD.
- ACCUM:
  - DIGIT with cnt = MAX_DIGITS: err pulse, go DISCARD.
  - DIGIT with acc*10 + d > 255: err pulse, go DISCARD. Compute in ≥12-bit intermediate; compare before truncating.
  - DIGIT otherwise: acc = acc*10 + d, cnt += 1.
  - TERM: value = acc, value_valid pulse, go IDLE.
  - OTHER: err pulse, go DISCARD.
  - tmr expiry: err pulse, go IDLE.
- DISCARD:
  - TERM: go IDLE with no strobe.
  - Any other byte: ignored.
  - tmr expiry: go IDLE with no strobe, since the error was already reported.
- Timer:
  - Cleared on every accepted byte and in IDLE.
  - Increments each cycle in ACCUM or DISCARD.
  - Expiry occurs when tmr reaches TIMEOUT_CYCLES-1 with no rx_valid that cycle.
- value_valid and err are never high in the same cycle.
- At most one err pulse per line.

## Timing
- Reset (asynchronous, immediate): state = IDLE, acc = 0, cnt = 0, tmr = 0, value = 0x00, value_valid = 0, err = 0, busy = 0.
- Reset mid-line: the partial line is lost. The next byte after reset release is treated as the start of a new line.
- All outputs are registered. value_valid or err asserts in the cycle after the clock edge that samples the triggering rx_valid, and lasts exactly one cycle.
- value changes in the same cycle value_valid rises.
- Back-to-back rx_valid: every byte is processed, at one byte per cycle throughput with no stall. A TERM immediately followed by a DIGIT in the next cycle yields a value_valid pulse and then starts a new line.
- Simultaneous rx_valid and timer expiry: the byte wins. It is processed normally, tmr clears, and no timeout error is raised.
- busy rises in the cycle after the first byte of a line (DIGIT or OTHER). It falls in the cycle after the TERM or expiry that returns the FSM to IDLE.

## Test plan
- Reset, then "1","2","8",CR on consecutive cycles → value = 0x80 with value_valid for one cycle; err stays 0; busy = 0 afterwards.
- "2","5","6",CR → err pulse one cycle after '6'; no value_valid on CR; value keeps its prior contents. Then "2","5","5",LF → value = 0xFF.
- "0","0","7","3",CR with MAX_DIGITS = 3 → err pulse after '3'; CR is silent. Then CR,LF alone → no strobes at all.
- "9","a","5",CR → single err pulse after 'a'; no further err or value_valid.
- With TIMEOUT_CYCLES = 16: send "4", then 16 idle cycles → err pulse and busy = 0. Repeat, but send "2" exactly on the expiry cycle followed by CR → value = 42 and no err.
- Send "1","9", assert rst for 2 cycles mid-line, release, then "3",CR → value = 3 (not 193); all outputs read 0 during reset.
